fifo_burst_arbiter: RTL and testbench
=====================================

Name: fifo_burst_arbiter

Overview:
- Shares a single output (write) FIFO between WIDTH input FWFT FIFOs.
- Grants one input at a time and holds the grant for a whole packet (PACKET_MODE=1) or for a burst of up to BURST_MAX words (PACKET_MODE=0).
- Rotates round-robin between grants.
- Sits in front of the output FIFO, in place of word-interleaving combiners, wherever packets must stay contiguous.

Parameters:
- WIDTH, 4: number of input FIFO ports, must be >=2.
- WIDTH_W, clogb2(WIDTH): port index width.
- DATA_W, 32: data word width.
- PACKET_MODE, 1: 1 = release grant only on a word with r_last set; 0 = release on burst limit or on input empty.
- BURST_MAX, 8: PACKET_MODE=0 only; maximum words per grant, must be >=1.
- CNT_W, clogb2(BURST_MAX+1): burst counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- r_empty  in  WIDTH  empty flags of the input FWFT FIFOs
- r_req  out  WIDTH  read strobes, at most one bit set
- r_data  in  WIDTH x DATA_W  input FIFO head words
- r_last  in  WIDTH  end-of-packet flag of each head word
- w_full  in  1  output FIFO full
- w_req  out  1  output write strobe
- w_data  out  DATA_W  output word
- w_last  out  1  end-of-packet flag of the output word
- w_src  out  WIDTH_W  source port index of the output word
- busy  out  1  a grant is held
- grant_idx  out  WIDTH_W  currently or last granted port

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE, busy=0, grant_idx=0, burst counter=0.
  - Round-robin pointer goes to WIDTH-1, so port 0 has first priority.
- Combinational outputs while rst=1: r_req=0, w_req=0, w_data=0, w_last=0, w_src=0.
- States: IDLE and LOCKED.
- IDLE:
  - The arbitration cycle; no read or write takes place.
  - If any r_empty bit is 0, select the first non-empty port scanning ptr+1, ptr+2, ... modulo WIDTH.
  - Next cycle: LOCKED, grant_idx=selected port, counter=0, busy=1.
  - If all inputs are empty, stay in IDLE.
- LOCKED (g = grant_idx):
  - A transfer happens when r_empty[g]=0 and w_full=0.
  - Transfer outputs, combinational in the same cycle: r_req[g]=1, w_req=1, w_data=r_data[g], w_last=r_last[g], w_src=g.
  - The counter increments on each transfer.
  - With no transfer, all outputs are 0; w_full stalls the grant indefinitely with no loss.
- Release with PACKET_MODE=1: only on a transfer with r_last[g]=1. An empty input mid-packet holds the grant (waits).
- Release with PACKET_MODE=0, whichever comes first:
  - A transfer that brings the counter to BURST_MAX.
  - A cycle in LOCKED with r_empty[g]=1 and no transfer.
  - r_last has no effect in this mode.
- On release:
  - Next state is IDLE, ptr=g, busy=0; grant_idx keeps g.
  - There is always one idle arbitration cycle between grants.
- Throughput: one word per cycle while locked; at best N/(N+1) across grants of N words.
- Fairness: a port that stays non-empty is granted within WIDTH-1 grants of other ports.
- Reset mid-packet aborts the lock immediately. Any partially read packet is the upstream's responsibility. The next grant starts from port 0.
- Simultaneous w_full=1 and r_last=1: no transfer and no release; the grant stays held.
- The counter never exceeds BURST_MAX and does not wrap.

Decomposition:
- No package needed.
- Include clogb2.svh for WIDTH_W and CNT_W.
- One natural sub-module, fifo_arb_select (combinational): inputs req vector and ptr; outputs valid and one-hot/binary index of the first request after ptr, with wrap-around.
- The FSM, counter, pointer and output muxing stay in fifo_burst_arbiter.

Test Plan:
- Reset, WIDTH=4, PACKET_MODE=1, all four ports non-empty, each holding a 3-word packet (last on word 3):
  - Grants go in order 0,1,2,3.
  - w_src sequence is 0,0,0,1,1,1,2,2,2,3,3,3, with one idle cycle between groups.
  - w_last is set on every third word.
- PACKET_MODE=1, port 2 goes empty after word 1 of 4 for 5 cycles, port 0 non-empty:
  - The grant holds on port 2 and w_req=0 for those 5 cycles.
  - Words 2-4 then follow from port 2 before port 0 is served.
- PACKET_MODE=0, BURST_MAX=4, port 1 holding 10 words, others empty:
  - Grants of 4, 4 and 2 words, each separated by one idle cycle.
  - The third grant releases on empty.
- w_full pulsed high for 3 cycles mid-burst:
  - w_req=0 and r_req=0 during the pulse.
  - No word lost or duplicated; the data sequence is unchanged.
- rst asserted while LOCKED on port 3 mid-packet, all ports non-empty:
  - Next cycle busy=0 and all outputs 0.
  - After rst is released, the first grant goes to port 0.
- Random stimulus, 10k cycles:
  - Popcount(r_req)<=1 every cycle.
  - Words from different ports are never interleaved inside a packet.

Source files
------------

// File: rtl/clogb2.svh
// Ceiling log2 helper used to size index and counter fields.
`ifndef CLOGB2_SVH
`define CLOGB2_SVH
function automatic int clogb2(input int value);
  int r;
  r = 0;
  for (int v = value - 1; v > 0; v = v >> 1) r++;
  if (r == 0) r = 1;
  return r;
endfunction
`endif

// File: rtl/fifo_arb_select.sv
// Round-robin pick: first asserted request strictly after ptr, wrapping.
`include "clogb2.svh"
module fifo_arb_select #(
  parameter int WIDTH   = 4,
  parameter int WIDTH_W = clogb2(WIDTH)
)(
  input  logic [WIDTH-1:0]   req_i,
  input  logic [WIDTH_W-1:0] ptr_i,
  output logic               valid_o,
  output logic [WIDTH_W-1:0] idx_o,
  output logic [WIDTH-1:0]   onehot_o
);
  logic [WIDTH_W-1:0] p;

  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    p        = '0;
    for (int i = WIDTH; i >= 1; i--) begin
      p = WIDTH_W'((int'(ptr_i) + i) % WIDTH);
      if (req_i[p]) begin
        valid_o = 1'b1;
        idx_o   = p;
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/fifo_burst_arbiter.sv
// Shares one output FIFO among WIDTH FWFT input FIFOs; the grant is held for a
// whole packet (PACKET_MODE=1) or a burst of up to BURST_MAX words.
`include "clogb2.svh"
module fifo_burst_arbiter #(
  parameter int WIDTH       = 4,
  parameter int WIDTH_W     = clogb2(WIDTH),
  parameter int DATA_W      = 32,
  parameter bit PACKET_MODE = 1'b1,
  parameter int BURST_MAX   = 8,
  parameter int CNT_W       = clogb2(BURST_MAX + 1)
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              r_empty,
  output logic [WIDTH-1:0]              r_req,
  input  logic [WIDTH-1:0][DATA_W-1:0]  r_data,
  input  logic [WIDTH-1:0]              r_last,
  input  logic                          w_full,
  output logic                          w_req,
  output logic [DATA_W-1:0]             w_data,
  output logic                          w_last,
  output logic [WIDTH_W-1:0]            w_src,
  output logic                          busy,
  output logic [WIDTH_W-1:0]            grant_idx
);
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_W-1:0] grant_q, grant_d;
  logic [WIDTH-1:0]   gnt_oh_q, gnt_oh_d;
  logic [WIDTH_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               sel_valid;
  logic [WIDTH_W-1:0] sel_idx;
  logic [WIDTH-1:0]   sel_oh;
  logic               xfer;
  logic               rel;

  // IDLE only looks at non-empty ports; arbitration never reads data.
  fifo_arb_select #(.WIDTH(WIDTH), .WIDTH_W(WIDTH_W)) u_sel (
    .req_i    (~r_empty),
    .ptr_i    (ptr_q),
    .valid_o  (sel_valid),
    .idx_o    (sel_idx),
    .onehot_o (sel_oh)
  );

  // A word moves only while locked, the granted input has data and the sink has room.
  assign xfer = !rst && (state_q == LOCKED) && !r_empty[grant_q] && !w_full;

  // Packet mode ends on the last word only; burst mode ends on the limit or when the input runs dry.
  assign rel = PACKET_MODE ? (xfer && r_last[grant_q])
                           : ((xfer && (cnt_q == CNT_W'(BURST_MAX - 1))) || r_empty[grant_q]);

  assign busy      = (state_q == LOCKED);
  assign grant_idx = grant_q;

  // Transfer-cycle output mux; everything is zero when no word moves.
  always_comb begin
    r_req  = '0;
    w_req  = 1'b0;
    w_data = '0;
    w_last = 1'b0;
    w_src  = '0;
    if (xfer) begin
      r_req  = gnt_oh_q;
      w_req  = 1'b1;
      w_data = r_data[grant_q];
      w_last = r_last[grant_q];
      w_src  = grant_q;
    end
  end

  // Next state: arbitrate in IDLE, count and release in LOCKED.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d  = LOCKED;
          grant_d  = sel_idx;
          gnt_oh_d = sel_oh;
          cnt_d    = '0;
        end
      end
      LOCKED: begin
        // Saturate so a long packet can never wrap the counter.
        if (xfer && (cnt_q != CNT_W'(BURST_MAX))) cnt_d = cnt_q + 1'b1;
        if (rel) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to the top port so port 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_oh_q <= WIDTH'(1);
      ptr_q    <= WIDTH_W'(WIDTH - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Scoreboard bench: DUT 0 in packet mode, DUT 1 in burst mode (BURST_MAX=4).
module tb_fifo_burst_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       r_empty [2];
  logic [N-1:0]       r_req   [2];
  logic [N-1:0]       r_last  [2];
  logic [N-1:0][31:0] r_data  [2];
  logic               w_full  [2];
  logic               w_req   [2];
  logic               w_last  [2];
  logic               busy    [2];
  logic [31:0]        w_data  [2];
  logic [1:0]         w_src   [2];
  logic [1:0]         grant_idx [2];

  fifo_burst_arbiter #(.WIDTH(N), .DATA_W(32), .PACKET_MODE(1'b1), .BURST_MAX(8)) u_pkt (
    .clk(clk), .rst(rst), .r_empty(r_empty[0]), .r_req(r_req[0]), .r_data(r_data[0]),
    .r_last(r_last[0]), .w_full(w_full[0]), .w_req(w_req[0]), .w_data(w_data[0]),
    .w_last(w_last[0]), .w_src(w_src[0]), .busy(busy[0]), .grant_idx(grant_idx[0]));

  fifo_burst_arbiter #(.WIDTH(N), .DATA_W(32), .PACKET_MODE(1'b0), .BURST_MAX(4)) u_brst (
    .clk(clk), .rst(rst), .r_empty(r_empty[1]), .r_req(r_req[1]), .r_data(r_data[1]),
    .r_last(r_last[1]), .w_full(w_full[1]), .w_req(w_req[1]), .w_data(w_data[1]),
    .w_last(w_last[1]), .w_src(w_src[1]), .busy(busy[1]), .grant_idx(grant_idx[1]));

  // Input FIFO contents, and per-port words still expected at the output.
  logic [32:0] inq  [2][N][$];
  logic [32:0] expq [2][N][$];
  int          srcq [2][$];
  int          runq [2][$];
  logic [N-1:0] hold [2];
  logic [N-1:0] pm   [2];
  logic [N-1:0] openin [2];
  int  ncmp = 0, nerr = 0;
  int  run [2];
  bit  opn [2];
  int  osrc [2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd();
    logic [32:0] t;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++) begin
        r_empty[d][p] = hold[d][p] || (inq[d][p].size() == 0);
        if (inq[d][p].size() > 0) begin
          t = inq[d][p][0];
          r_data[d][p] = t[31:0];
          r_last[d][p] = t[32];
        end else begin
          r_data[d][p] = '0;
          r_last[d][p] = 1'b0;
        end
      end
  endtask

  task automatic push(int d, int p, logic [31:0] data, logic last);
    inq[d][p].push_back({last, data});
    expq[d][p].push_back({last, data});
  endtask

  task automatic load_pkt(int d, int p, int len);
    for (int i = 1; i <= len; i++) push(d, p, $urandom, (i == len));
  endtask

  // One clock: capture read strobes mid-cycle, pop the accepted heads after the edge.
  task automatic cyc();
    logic [32:0] t;
    @(negedge clk);
    for (int d = 0; d < 2; d++) pm[d] = r_req[d];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        if (pm[d][p] && inq[d][p].size() > 0) t = inq[d][p].pop_front();
    upd();
  endtask

  task automatic drain(int budget);
    int n;
    bit pend;
    n = 0;
    for (int d = 0; d < 2; d++) w_full[d] = 1'b0;
    upd();
    forever begin
      pend = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) pend = 1'b1;
        for (int p = 0; p < N; p++) if (inq[d][p].size() > 0) pend = 1'b1;
      end
      if (!pend) break;
      if (n >= budget) begin
        chk("drain_timeout", 1, 0);
        break;
      end
      cyc();
      n++;
    end
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) chk("leftover_words", expq[d][p].size(), 0);
      chk("unseen_src", srcq[d].size(), 0);
      chk("unseen_runs", runq[d].size(), 0);
    end
  endtask

  // Monitor: compares every presented output word against the scoreboard.
  task automatic mon(int d);
    logic [32:0] e;
    int s;
    if (rst) begin
      chk("rst_outputs", {r_req[d], w_req[d], w_data[d], w_last[d], w_src[d]}, 0);
      opn[d] = 1'b0;
      run[d] = 0;
      return;
    end
    chk("req_onehot", ($countones(r_req[d]) <= 1), 1);
    if (w_full[d]) chk("full_stall", {r_req[d], w_req[d]}, 0);
    if (w_req[d]) begin
      s = int'(w_src[d]);
      chk("req_matches_src", r_req[d], 4'b0001 << s);
      chk("busy_on_write", busy[d], 1);
      chk("word_expected", expq[d][s].size() > 0, 1);
      if (expq[d][s].size() > 0) begin
        e = expq[d][s].pop_front();
        chk("data_last", {w_last[d], w_data[d]}, e);
      end
      if (srcq[d].size() > 0) chk("src_order", s, srcq[d].pop_front());
      if (d == 0 && opn[d]) chk("packet_contiguous", s, osrc[d]);
      opn[d]  = !w_last[d];
      osrc[d] = s;
      run[d]++;
    end else begin
      if (run[d] > 0 && runq[d].size() > 0) chk("run_length", run[d], runq[d].pop_front());
      run[d] = 0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) mon(d);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int pops;
    logic lst;
    for (int d = 0; d < 2; d++) begin
      w_full[d] = 1'b0; hold[d] = '0; openin[d] = '0; run[d] = 0; opn[d] = 1'b0; osrc[d] = 0;
    end
    upd();
    repeat (2) cyc();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_grant_idx", grant_idx[d], 0);
    end

    // Four 3-word packets: served 0,1,2,3 with an idle cycle between them.
    for (int p = 0; p < N; p++) begin
      load_pkt(0, p, 3);
      for (int i = 0; i < 3; i++) srcq[0].push_back(p);
      runq[0].push_back(3);
    end
    upd();
    rst = 1'b0;
    drain(200);

    // Port 2 runs dry after its first word; the grant must wait for it.
    load_pkt(0, 2, 4);
    srcq[0].push_back(2); srcq[0].push_back(2); srcq[0].push_back(2); srcq[0].push_back(2);
    srcq[0].push_back(0); srcq[0].push_back(0);
    runq[0].push_back(1); runq[0].push_back(3); runq[0].push_back(2);
    upd();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (pm[0][2]) seen = 1'b1;
    end
    chk("t2_first_word", seen, 1);
    hold[0][2] = 1'b1;
    load_pkt(0, 0, 2);
    upd();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_noreq", pm[0], 0);
      chk("t2_hold_grant", {busy[0], grant_idx[0]}, {1'b1, 2'd2});
    end
    hold[0][2] = 1'b0;
    upd();
    drain(200);

    // Burst mode: 10 words on port 1 come out as bursts of 4, 4, 2.
    for (int i = 1; i <= 10; i++) push(1, 1, $urandom, (i == 3));
    for (int i = 0; i < 10; i++) srcq[1].push_back(1);
    runq[1].push_back(4); runq[1].push_back(4); runq[1].push_back(2);
    upd();
    drain(200);

    // Output full for 3 cycles in the middle of a packet.
    load_pkt(0, 1, 6);
    for (int i = 0; i < 6; i++) srcq[0].push_back(1);
    runq[0].push_back(2); runq[0].push_back(4);
    upd();
    pops = 0;
    for (int i = 0; i < 40 && pops < 2; i++) begin
      cyc();
      if (pm[0][1]) pops++;
    end
    chk("t4_two_words", pops, 2);
    w_full[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_full_noreq", pm[0], 0);
    end
    w_full[0] = 1'b0;
    drain(200);

    // Reset while locked mid-packet on port 3.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int p = 0; p < N; p++) load_pkt(0, p, 4);
    upd();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      if (pm[0][3]) seen = 1'b1;
    end
    chk("t5_locked_port3", seen, 1);
    rst = 1'b1;
    cyc();
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_grant_idx", grant_idx[0], 0);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) begin
        inq[d][p].delete();
        expq[d][p].delete();
      end
      srcq[d].delete();
      runq[d].delete();
    end
    for (int p = 0; p < N; p++) begin
      load_pkt(0, p, 2);
      srcq[0].push_back(p); srcq[0].push_back(p);
    end
    upd();
    cyc();
    rst = 1'b0;
    drain(200);

    // Random traffic on both DUTs with random back-pressure.
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        w_full[d] = ($urandom_range(7) == 0);
        for (int p = 0; p < N; p++)
          if (inq[d][p].size() < 6 && $urandom_range(3) == 0) begin
            lst = ($urandom_range(3) == 0);
            push(d, p, $urandom, lst);
            openin[d][p] = !lst;
          end
      end
      upd();
      cyc();
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        if (openin[d][p]) push(d, p, $urandom, 1'b1);
    upd();
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
